// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and hex-to-segment table for the 7-segment scan driver
// Contents:
//   seg_t       segment vector in a..g order, seg[0] = a, active-low
//   SEG_OFF     all segments dark
//   HEX_TABLE   16-entry nibble -> active-low segment pattern
//   hex_to_seg  table lookup helper
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Bit order is a,b,c,d,e,f,g left to right; 0 lights the segment.
    localparam seg_t HEX_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational nibble to 7-segment pattern lookup
// Ports:
//   nibble_i  4-bit hex digit
//   seg_o     active-low segments a..g (seg_o[0] = a)
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed NUM_DIGITS common-anode 7-segment driver
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   value   hex nibbles, nibble i = value[4i+3:4i], digit 0 least significant
//   load    capture value; takes effect at the next frame boundary
//   lz_en   blank leading zero digits (digit 0 always shown)
//   dp_in   per-digit decimal point request, sampled live (1 = lit)
//   seg     segments a..g, seg[0] = a, active-low, registered
//   dp      decimal point, active-low, registered
//   an      anode enables, active-low, registered, at most one low
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int               DIV_W     = $clog2(REFRESH_DIV);
    localparam int               VAL_W     = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick;
    logic                  frame_end;
    logic                  in_blank;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_lz_blank;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic                  zero_run;
    seg_t                  lut_seg;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);
    assign in_blank  = (div_cnt_q < BLANK_END);

    // Divider and scan index
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Loads are parked in the shadow and only promoted at the frame boundary,
    // so a frame is always drawn from a single value. A load landing on the
    // boundary cycle bypasses the shadow so it is not deferred a whole frame.
    always_comb begin
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (load) begin
                disp_d = value;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are
    // zero. Walk down from the top digit accumulating that condition; digit 0
    // is never considered.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (disp_q[4*k +: 4] == 4'h0);
            lz_blank[k] = lz_en && zero_run && !dp_in[k];
        end
    end

    // Select the current digit's nibble, dp request and suppression flag
    always_comb begin
        cur_nibble   = 4'h0;
        cur_dp       = 1'b0;
        cur_lz_blank = 1'b0;
        sel_onehot   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nibble    = disp_q[4*k +: 4];
                cur_dp        = dp_in[k];
                cur_lz_blank  = lz_blank[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    seg7_hex_lut u_hex_lut (
        .nibble_i (cur_nibble),
        .seg_o    (lut_seg)
    );

    // Pin values for the next cycle; the blank window at the start of each
    // slot gives the previous digit's anode time to turn off before the
    // segment bus changes, which suppresses ghosting.
    always_comb begin
        an_d  = ~sel_onehot;
        seg_d = lut_seg;
        dp_d  = ~cur_dp;
        if (in_blank || cur_lz_blank) begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  value;
    logic         load;
    logic         lz_en;
    logic [3:0]   dp_in;
    logic [0:6]   seg;
    logic         dp;
    logic [3:0]   an;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .lz_en (lz_en),
        .dp_in (dp_in),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode table, a..g left to right, 0 = lit
    logic [0:6] ref_dec [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: time is an absolute cycle count since reset; slot and
    // position within the slot are plain div/mod of it. The shown value
    // becomes the last value loaded during the frame (boundary cycle
    // included) once that frame ends.
    int unsigned m_cyc;
    logic [15:0] m_disp;
    logic [15:0] m_last;
    bit          m_has;
    bit          m_live = 1'b0;
    logic [0:6]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;

    always @(posedge clk or posedge rst) begin
        int pos;
        int slot;
        logic [15:0] upper;
        if (rst) begin
            m_cyc  = 0;
            m_disp = '0;
            m_has  = 1'b0;
            e_seg  = 7'b1111111;
            e_dp   = 1'b1;
            e_an   = 4'b1111;
            m_live = 1'b1;
        end else begin
            pos   = int'(m_cyc % R);
            slot  = int'((m_cyc / R) % N);
            upper = m_disp >> (4 * slot);
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
            e_an  = 4'b1111;
            if (pos >= B && !(lz_en && slot != 0 && upper == 16'h0 && !dp_in[slot])) begin
                e_an  = ~(4'b0001 << slot);
                e_seg = ref_dec[upper[3:0]];
                e_dp  = ~dp_in[slot];
            end
            if (load) begin
                m_last = value;
                m_has  = 1'b1;
            end
            if (pos == R - 1 && slot == N - 1) begin
                if (m_has) m_disp = m_last;
                m_has = 1'b0;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_an", 32'(an), 32'(e_an));
            check("model_dp", 32'(dp), 32'(e_dp));
            check("one_anode", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench just before the frame-boundary cycle
    task automatic to_boundary();
        for (int i = 0; i < 200; i++) begin
            if ((m_cyc % R) == R - 1 && ((m_cyc / R) % N) == N - 1) return;
            step(1);
        end
        check("boundary_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    // Called just after a boundary edge; walks the following frame slot by slot
    task automatic scan_frame(input string tag, input logic [3:0] xan [4],
                              input logic [0:6] xseg [4], input logic [3:0] xdp);
        for (int s = 0; s < N; s++) begin
            step(1);
            check({tag, "_blank_first"}, 32'(an), 32'hf);
            step(B - 1);
            check({tag, "_blank_last"}, 32'(an), 32'hf);
            step(1);
            check({tag, "_an"}, 32'(an), 32'(xan[s]));
            check({tag, "_seg"}, 32'(seg), 32'(xseg[s]));
            check({tag, "_dp"}, 32'(dp), 32'(xdp[s]));
            step(R - B - 1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        lz_en = 1'b0;
        dp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_dp", 32'(dp), 32'd1);
        rst = 1'b0;
        step(B);
        check("rel_blank", 32'(an), 32'hf);
        step(1);
        check("rel_digit0", 32'(an), 32'he);

        // Load at the boundary
        to_boundary();
        value = 16'h12AF;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        scan_frame("f12af", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                   '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111}, 4'b1111);

        // Mid-frame load of zero must wait for the next frame
        step(R + 3);
        pulse_load(16'h0000);
        step(2 * R + B - 3);
        check("midload_hold_seg", 32'(seg), 32'(7'b1001111));
        check("midload_hold_an", 32'(an), 32'h7);
        step(R);
        check("midload_new_seg", 32'(seg), 32'(7'b0000001));
        check("midload_new_an", 32'(an), 32'he);

        // Leading-zero suppression, then a dp request overriding it
        lz_en = 1'b1;
        pulse_load(16'h0070);
        to_boundary();
        step(1);
        scan_frame("lz", '{4'b1110, 4'b1101, 4'b1111, 4'b1111},
                   '{7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111}, 4'b1111);
        dp_in = 4'b0100;
        scan_frame("lzdp", '{4'b1110, 4'b1101, 4'b1011, 4'b1111},
                   '{7'b0000001, 7'b0001111, 7'b0000001, 7'b1111111}, 4'b1011);
        dp_in = 4'b0000;
        lz_en = 1'b0;

        // Back-to-back loads: last wins
        to_boundary();
        step(3);
        pulse_load(16'h1111);
        pulse_load(16'h2222);
        pulse_load(16'h3333);
        to_boundary();
        step(1);
        scan_frame("b2b", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                   '{7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110}, 4'b1111);

        // Load coinciding with the boundary
        to_boundary();
        value = 16'hBEEF;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        scan_frame("beef", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                   '{7'b0111000, 7'b0110000, 7'b0110000, 7'b1100000}, 4'b1111);

        // Asynchronous reset between clock edges
        step(3 * R + 4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hf);
        check("async_rst_seg", 32'(seg), 32'h7f);
        check("async_rst_dp", 32'(dp), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        step(B);
        check("arst_rel_blank", 32'(an), 32'hf);
        step(1);
        check("arst_rel_digit0", 32'(an), 32'he);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] mask;
            mask  = {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                     {4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}};
            value = 16'($urandom) & mask;
            load  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 47) == 0) dp_in = 4'($urandom);
            step(1);
        end
        load = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
